// File: rtl/sd_spi_card_emu.sv
// sd_spi_card_emu: SPI-mode SD card emulator answering CMD0, CMD8, CMD55, ACMD41 and CMD17.
// It oversamples the host SPI pins on the system clock and serves read blocks from an external byte source.
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   sclk, cs_n, mosi      host SPI inputs, asynchronous to clk
//   miso                  registered card output, 1 when idle
//   rd_stb/rd_blk/rd_idx  byte request to the data source; rd_data sampled 2 clk after rd_stb
//   cmd_stb, cmd_idx      pulse and index of each valid 48-bit command frame
//   card_ready            set once ACMD41 has answered 0x00
module sd_spi_card_emu #(
  parameter int unsigned BLOCK_LEN   = 512,
  parameter int unsigned NCR         = 1,
  parameter int unsigned NAC         = 2,
  parameter int unsigned ACMD41_BUSY = 1,
  parameter int unsigned INIT_CLKS   = 74,
  parameter int unsigned NUM_BLOCKS  = 65536
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         sclk,
  input  logic                         cs_n,
  input  logic                         mosi,
  output logic                         miso,
  output logic                         rd_stb,
  output logic [31:0]                  rd_blk,
  output logic [$clog2(BLOCK_LEN)-1:0] rd_idx,
  input  logic [7:0]                   rd_data,
  output logic                         cmd_stb,
  output logic [5:0]                   cmd_idx,
  output logic                         card_ready
);
  localparam int unsigned IDX_W  = $clog2(BLOCK_LEN);
  localparam int unsigned CNT_W  = 11;
  localparam int unsigned INIT_W = 16;

  localparam logic [2:0] ST_RX    = 3'd0;
  localparam logic [2:0] ST_NCR   = 3'd1;
  localparam logic [2:0] ST_RESP  = 3'd2;
  localparam logic [2:0] ST_NAC   = 3'd3;
  localparam logic [2:0] ST_TOKEN = 3'd4;
  localparam logic [2:0] ST_DATA  = 3'd5;
  localparam logic [2:0] ST_CRC   = 3'd6;

  logic [2:0]        sclk_q, cs_q, mosi_q;
  logic [2:0]        st_q, st_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [2:0]        bit_q, bit_d;
  logic [7:0]        sh_q, sh_d;
  logic              miso_q, miso_d;
  logic              rx_act_q, rx_act_d;
  logic [5:0]        rx_cnt_q, rx_cnt_d;
  logic [46:0]       rx_sh_q, rx_sh_d;
  logic              idle_q, idle_d, app_q, app_d, ready_q, ready_d;
  logic [3:0]        acnt_q, acnt_d;
  logic [39:0]       resp_q, resp_d;
  logic [2:0]        resp_last_q, resp_last_d;
  logic              data_q, data_d;
  logic [INIT_W-1:0] init_cnt_q, init_cnt_d;
  logic              stb_pend_q, stb_pend_d, rd_stb_q, rd_stb_d, cap_q, cap_d;
  logic [7:0]        pre_q, pre_d;
  logic [31:0]       rd_blk_q, rd_blk_d;
  logic [IDX_W-1:0]  rd_idx_q, rd_idx_d;
  logic [15:0]       crc_q, crc_d;
  logic              cmd_stb_q, cmd_stb_d;
  logic [5:0]        cmd_idx_q, cmd_idx_d;

  logic        rise_c, fall_c, cs_hi, mosi_s, init_done;
  logic [47:0] frame;
  logic [5:0]  f_idx;
  logic [31:0] f_arg;
  logic [7:0]  f_crc, r1, r1_idle;
  logic        r7;

  // Edge events come from the second sync stage against its delayed copy
  assign rise_c    = sclk_q[1] & ~sclk_q[2];
  assign fall_c    = ~sclk_q[1] & sclk_q[2];
  assign cs_hi     = cs_q[1];
  assign mosi_s    = mosi_q[1];
  assign init_done = init_cnt_q >= INIT_W'(INIT_CLKS);
  assign frame     = {rx_sh_q, mosi_s};
  assign f_idx     = frame[45:40];
  assign f_arg     = frame[39:8];
  assign f_crc     = frame[7:0];
  assign r1_idle   = {7'd0, idle_q};

  // CRC16-CCITT (0x1021) advanced by one byte, MSB first
  function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    logic        fb;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      fb = r[15] ^ b[i];
      r  = {r[14:0], 1'b0};
      if (fb) r = r ^ 16'h1021;
    end
    return r;
  endfunction

  // Next-state logic: receiver, command decode and byte-serial transmitter
  always_comb begin
    st_d = st_q; cnt_d = cnt_q; bit_d = bit_q; sh_d = sh_q; miso_d = miso_q;
    rx_act_d = rx_act_q; rx_cnt_d = rx_cnt_q; rx_sh_d = rx_sh_q;
    idle_d = idle_q; app_d = app_q; ready_d = ready_q; acnt_d = acnt_q;
    resp_d = resp_q; resp_last_d = resp_last_q; data_d = data_q;
    init_cnt_d = init_cnt_q;
    stb_pend_d = 1'b0; rd_stb_d = stb_pend_q; cap_d = rd_stb_q; pre_d = pre_q;
    rd_blk_d = rd_blk_q; rd_idx_d = rd_idx_q; crc_d = crc_q;
    cmd_stb_d = 1'b0; cmd_idx_d = cmd_idx_q;
    r1 = 8'h00; r7 = 1'b0;

    if (cap_q) pre_d = rd_data;
    if (rise_c && cs_hi && !init_done) init_cnt_d = init_cnt_q + INIT_W'(1);

    if (cs_hi) begin
      // Deselect aborts any transfer; card flags survive
      st_d = ST_RX; rx_act_d = 1'b0; rx_cnt_d = 6'd0; bit_d = 3'd0; miso_d = 1'b1;
      stb_pend_d = 1'b0; rd_stb_d = 1'b0; cap_d = 1'b0;
    end else if (st_q == ST_RX) begin
      if (fall_c) miso_d = 1'b1;
      if (rise_c && init_done) begin
        if (!rx_act_q) begin
          if (!mosi_s) begin
            rx_act_d = 1'b1; rx_cnt_d = 6'd1; rx_sh_d = '0;
          end
        end else if (rx_cnt_q == 6'd47) begin
          rx_act_d = 1'b0; rx_cnt_d = 6'd0;
          if (!frame[47] && frame[46]) begin
            cmd_stb_d = 1'b1; cmd_idx_d = f_idx; app_d = 1'b0;
            resp_last_d = 3'd0; data_d = 1'b0;
            case (f_idx)
              6'd0: begin
                if (f_crc == 8'h95) begin
                  idle_d = 1'b1; acnt_d = 4'd0; ready_d = 1'b0; r1 = 8'h01;
                end else r1 = 8'h08 | r1_idle;
              end
              6'd8: begin
                if (f_crc == 8'h87) begin
                  r7 = 1'b1; resp_last_d = 3'd4;
                end else r1 = 8'h08 | r1_idle;
              end
              6'd55: begin
                r1 = r1_idle; app_d = 1'b1;
              end
              6'd41: begin
                if (!app_q) r1 = 8'h04 | r1_idle;
                else if (acnt_q < 4'(ACMD41_BUSY)) begin
                  acnt_d = acnt_q + 4'd1; r1 = 8'h01;
                end else begin
                  idle_d = 1'b0; ready_d = 1'b1; r1 = 8'h00;
                end
              end
              6'd17: begin
                if (idle_q) r1 = 8'h05;
                else if (f_arg >= NUM_BLOCKS) r1 = 8'h40;
                else begin
                  r1 = 8'h00; rd_blk_d = f_arg; data_d = 1'b1;
                end
              end
              default: r1 = 8'h04 | r1_idle;
            endcase
            resp_d = r7 ? {r1_idle, 8'h00, 8'h00, 4'h0, f_arg[11:8], f_arg[7:0]} : {r1, 32'hFFFF_FFFF};
            st_d = ST_NCR; cnt_d = '0; bit_d = 3'd0; sh_d = 8'hFF;
          end
        end else begin
          rx_cnt_d = rx_cnt_q + 6'd1; rx_sh_d = frame[46:0];
        end
      end
    end else if (fall_c) begin
      miso_d = sh_q[7];
      sh_d   = {sh_q[6:0], 1'b1};
      bit_d  = bit_q + 3'd1;
      // Request the next data byte as the first bit of the token or previous byte goes out
      if (bit_q == 3'd0 && (st_q == ST_TOKEN ||
          (st_q == ST_DATA && cnt_q != CNT_W'(BLOCK_LEN - 1)))) begin
        stb_pend_d = 1'b1;
        rd_idx_d   = (st_q == ST_TOKEN) ? '0 : IDX_W'(cnt_q + CNT_W'(1));
      end
      // Last bit of the current byte: pick the byte that starts on the next fall
      if (bit_q == 3'd7) begin
        case (st_q)
          ST_NCR: begin
            if (cnt_q == CNT_W'(NCR - 1)) begin
              st_d = ST_RESP; cnt_d = '0; sh_d = resp_q[39:32]; resp_d = {resp_q[31:0], 8'hFF};
            end else begin
              cnt_d = cnt_q + CNT_W'(1); sh_d = 8'hFF;
            end
          end
          ST_RESP: begin
            if (cnt_q == CNT_W'(resp_last_q)) begin
              if (data_q) begin
                st_d = ST_NAC; cnt_d = '0; sh_d = 8'hFF;
              end else st_d = ST_RX;
            end else begin
              cnt_d = cnt_q + CNT_W'(1); sh_d = resp_q[39:32]; resp_d = {resp_q[31:0], 8'hFF};
            end
          end
          ST_NAC: begin
            if (cnt_q == CNT_W'(NAC - 1)) begin
              st_d = ST_TOKEN; sh_d = 8'hFE;
            end else begin
              cnt_d = cnt_q + CNT_W'(1); sh_d = 8'hFF;
            end
          end
          ST_TOKEN: begin
            st_d = ST_DATA; cnt_d = '0; sh_d = pre_q; crc_d = crc16_byte(16'h0000, pre_q);
          end
          ST_DATA: begin
            if (cnt_q == CNT_W'(BLOCK_LEN - 1)) begin
              st_d = ST_CRC; cnt_d = '0; sh_d = crc_q[15:8];
            end else begin
              cnt_d = cnt_q + CNT_W'(1); sh_d = pre_q; crc_d = crc16_byte(crc_q, pre_q);
            end
          end
          ST_CRC: begin
            if (cnt_q == '0) begin
              cnt_d = CNT_W'(1); sh_d = crc_q[7:0];
            end else st_d = ST_RX;
          end
          default: st_d = ST_RX;
        endcase
      end
    end
  end

  // State and synchroniser registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sclk_q <= 3'b000; cs_q <= 3'b111; mosi_q <= 3'b111;
      st_q <= ST_RX; cnt_q <= '0; bit_q <= 3'd0; sh_q <= 8'hFF; miso_q <= 1'b1;
      rx_act_q <= 1'b0; rx_cnt_q <= 6'd0; rx_sh_q <= '0;
      idle_q <= 1'b1; app_q <= 1'b0; ready_q <= 1'b0; acnt_q <= 4'd0;
      resp_q <= '1; resp_last_q <= 3'd0; data_q <= 1'b0;
      init_cnt_q <= '0;
      stb_pend_q <= 1'b0; rd_stb_q <= 1'b0; cap_q <= 1'b0; pre_q <= 8'h00;
      rd_blk_q <= '0; rd_idx_q <= '0; crc_q <= 16'h0000;
      cmd_stb_q <= 1'b0; cmd_idx_q <= 6'd0;
    end else begin
      sclk_q <= {sclk_q[1:0], sclk}; cs_q <= {cs_q[1:0], cs_n}; mosi_q <= {mosi_q[1:0], mosi};
      st_q <= st_d; cnt_q <= cnt_d; bit_q <= bit_d; sh_q <= sh_d; miso_q <= miso_d;
      rx_act_q <= rx_act_d; rx_cnt_q <= rx_cnt_d; rx_sh_q <= rx_sh_d;
      idle_q <= idle_d; app_q <= app_d; ready_q <= ready_d; acnt_q <= acnt_d;
      resp_q <= resp_d; resp_last_q <= resp_last_d; data_q <= data_d;
      init_cnt_q <= init_cnt_d;
      stb_pend_q <= stb_pend_d; rd_stb_q <= rd_stb_d; cap_q <= cap_d; pre_q <= pre_d;
      rd_blk_q <= rd_blk_d; rd_idx_q <= rd_idx_d; crc_q <= crc_d;
      cmd_stb_q <= cmd_stb_d; cmd_idx_q <= cmd_idx_d;
    end
  end

  assign miso       = miso_q;
  assign rd_stb     = rd_stb_q;
  assign rd_blk     = rd_blk_q;
  assign rd_idx     = rd_idx_q;
  assign cmd_stb    = cmd_stb_q;
  assign cmd_idx    = cmd_idx_q;
  assign card_ready = ready_q;

endmodule

// File: tb/tb_sd_spi_card_emu.sv
// tb_sd_spi_card_emu: directed bench driving SPI-mode SD commands into sd_spi_card_emu.
// The data source returns rd_idx as the byte value; expected bytes are hand-derived,
// the block CRC comes from an augmented-message polynomial division model.
module tb_sd_spi_card_emu;
  localparam int unsigned BL   = 16;
  localparam int unsigned NB   = 1000;
  localparam int          HALF = 60;

  logic        clk = 1'b0;
  logic        rst_n, sclk, cs_n, mosi, miso, rd_stb, cmd_stb, card_ready;
  logic [31:0] rd_blk;
  logic [3:0]  rd_idx;
  logic [7:0]  rd_data;
  logic [5:0]  cmd_idx;

  int n_checks = 0;
  int n_fail   = 0;
  int stb_cnt  = 0;
  int cmd_cnt  = 0;
  int stb0;
  logic [7:0] rb [0:31];
  logic [7:0] tmp;

  sd_spi_card_emu #(
    .BLOCK_LEN(BL), .NCR(1), .NAC(2), .ACMD41_BUSY(2), .INIT_CLKS(74), .NUM_BLOCKS(NB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .sclk(sclk), .cs_n(cs_n), .mosi(mosi), .miso(miso),
    .rd_stb(rd_stb), .rd_blk(rd_blk), .rd_idx(rd_idx), .rd_data(rd_data),
    .cmd_stb(cmd_stb), .cmd_idx(cmd_idx), .card_ready(card_ready)
  );

  always #5 clk = ~clk;

  assign rd_data = {4'h0, rd_idx};

  always @(posedge clk) begin
    if (rd_stb)  stb_cnt <= stb_cnt + 1;
    if (cmd_stb) cmd_cnt <= cmd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Mode-0 host: MOSI set while SCLK low, MISO sampled at the rising edge
  task automatic spi_xfer(input logic [7:0] tx, input int nbits, output logic [7:0] rx);
    rx = 8'hFF;
    for (int i = 0; i < nbits; i++) begin
      mosi = tx[7-i];
      #HALF sclk = 1'b1;
      rx = {rx[6:0], miso};
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic idle_clks(input int n);
    cs_n = 1'b1; mosi = 1'b1;
    repeat (n) begin
      #HALF sclk = 1'b1;
      #HALF sclk = 1'b0;
    end
  endtask

  task automatic send_cmd(input logic [5:0] idx, input logic [31:0] arg, input logic [7:0] crc);
    logic [7:0] r;
    cs_n = 1'b0;
    spi_xfer({2'b01, idx}, 8, r);
    spi_xfer(arg[31:24], 8, r);
    spi_xfer(arg[23:16], 8, r);
    spi_xfer(arg[15:8], 8, r);
    spi_xfer(arg[7:0], 8, r);
    spi_xfer(crc, 8, r);
  endtask

  task automatic read_n(input int n);
    logic [7:0] r;
    for (int i = 0; i < n; i++) begin
      spi_xfer(8'hFF, 8, r);
      rb[i] = r;
    end
  endtask

  // Send a command and compare the first n returned bytes against exp (first byte most significant)
  task automatic run_cmd(input string tag, input logic [5:0] idx, input logic [31:0] arg,
                         input logic [7:0] crc, input int n, input logic [47:0] exp);
    send_cmd(idx, arg, crc);
    read_n(n);
    for (int i = 0; i < n; i++)
      check_eq($sformatf("%s b%0d", tag, i), 32'(rb[i]), 32'(exp[8*(n-1-i) +: 8]));
  endtask

  function automatic logic [15:0] ref_crc(input int n);
    logic [15:0] r;
    logic [7:0]  d;
    logic        top;
    r = 16'h0000;
    for (int i = 0; i < n + 2; i++) begin
      d = (i < n) ? 8'(i) : 8'h00;
      for (int j = 7; j >= 0; j--) begin
        top = r[15];
        r   = {r[14:0], d[j]};
        if (top) r = r ^ 16'h1021;
      end
    end
    return r;
  endfunction

  // Read a full CMD17 block (after the command) and check every byte
  task automatic check_block(input string tag, input logic [31:0] blk);
    logic [15:0] c;
    read_n(5 + BL + 2);
    check_eq({tag, " ncr"}, 32'(rb[0]), 32'hFF);
    check_eq({tag, " r1"}, 32'(rb[1]), 32'h00);
    check_eq({tag, " nac0"}, 32'(rb[2]), 32'hFF);
    check_eq({tag, " nac1"}, 32'(rb[3]), 32'hFF);
    check_eq({tag, " token"}, 32'(rb[4]), 32'hFE);
    for (int i = 0; i < BL; i++)
      check_eq($sformatf("%s data%0d", tag, i), 32'(rb[5+i]), 32'(i));
    c = ref_crc(BL);
    check_eq({tag, " crc"}, {16'h0, rb[5+BL], rb[6+BL]}, {16'h0, c});
    check_eq({tag, " rd_blk"}, rd_blk, blk);
    check_eq({tag, " stb count"}, 32'(stb_cnt - stb0), 32'(BL));
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    sclk = 1'b0; cs_n = 1'b1; mosi = 1'b1; rst_n = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check_eq("rst miso", 32'(miso), 32'h1);
    check_eq("rst rd_stb", 32'(rd_stb), 32'h0);
    check_eq("rst rd_blk", rd_blk, 32'h0);
    check_eq("rst rd_idx", 32'(rd_idx), 32'h0);
    check_eq("rst cmd_stb", 32'(cmd_stb), 32'h0);
    check_eq("rst cmd_idx", 32'(cmd_idx), 32'h0);
    check_eq("rst card_ready", 32'(card_ready), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Too few power-up clocks: frame ignored, MISO idle
    idle_clks(40);
    run_cmd("early cmd0", 6'd0, 32'h0, 8'h95, 2, 48'hFFFF);
    check_eq("early cmd_stb count", 32'(cmd_cnt), 32'd0);
    idle_clks(40);

    run_cmd("cmd0", 6'd0, 32'h0, 8'h95, 2, 48'hFF01);
    check_eq("cmd0 cmd_stb count", 32'(cmd_cnt), 32'd1);
    check_eq("cmd0 cmd_idx", 32'(cmd_idx), 32'd0);
    run_cmd("cmd0 badcrc", 6'd0, 32'h0, 8'h00, 2, 48'hFF09);
    run_cmd("cmd8", 6'd8, 32'h0000_01AA, 8'h87, 6, 48'hFF01_0000_01AA);
    check_eq("cmd8 cmd_idx", 32'(cmd_idx), 32'd8);
    run_cmd("cmd17 idle", 6'd17, 32'd5, 8'hFF, 2, 48'hFF05);
    run_cmd("cmd41 noapp", 6'd41, 32'h4000_0000, 8'hFF, 2, 48'hFF05);

    for (int k = 0; k < 3; k++) begin
      run_cmd($sformatf("cmd55 #%0d", k), 6'd55, 32'h0, 8'hFF, 2, 48'hFF01);
      run_cmd($sformatf("acmd41 #%0d", k), 6'd41, 32'h4000_0000, 8'hFF, 2,
              (k < 2) ? 48'hFF01 : 48'hFF00);
      check_eq($sformatf("card_ready #%0d", k), 32'(card_ready), (k < 2) ? 32'h0 : 32'h1);
    end

    // Out-of-range address: 0x40 and no token
    stb0 = stb_cnt;
    run_cmd("cmd17 range", 6'd17, 32'(NB), 8'hFF, 6, 48'hFF40_FFFF_FFFF);
    check_eq("cmd17 range stb", 32'(stb_cnt - stb0), 32'd0);

    stb0 = stb_cnt;
    send_cmd(6'd17, 32'd5, 8'hFF);
    check_block("blk5", 32'd5);

    // Deselect in the middle of data byte 7 (0x07): bits 7..4 read, bit 3 (0) on MISO
    stb0 = stb_cnt;
    send_cmd(6'd17, 32'd7, 8'hFF);
    read_n(12);
    check_eq("abort token", 32'(rb[4]), 32'hFE);
    check_eq("abort data6", 32'(rb[11]), 32'h06);
    spi_xfer(8'hFF, 4, tmp);
    check_eq("abort data7 hi", 32'(tmp[3:0]), 32'h0);
    repeat (4) @(posedge clk);
    #1 check_eq("abort miso before", 32'(miso), 32'h0);
    @(negedge clk);
    cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_eq("abort miso high", 32'(miso), 32'h1);
    check_eq("abort stb at cs", 32'(stb_cnt - stb0), 32'd9);
    @(negedge clk);
    idle_clks(16);
    check_eq("abort stb after", 32'(stb_cnt - stb0), 32'd9);
    check_eq("abort card_ready", 32'(card_ready), 32'h1);

    stb0 = stb_cnt;
    send_cmd(6'd17, 32'd3, 8'hFF);
    check_block("blk3", 32'd3);
    cs_n = 1'b1;
    repeat (10) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/sd_spi_card_emu.md
# sd_spi_card_emu

Synthesizable SPI-mode SD card emulator, clocked from the system clock. It oversamples the host's SCLK, CS and MOSI and answers CMD0, CMD8, CMD55, ACMD41 and CMD17 with cycle-accurate R1/R7 responses. Read data comes from an external byte source, and each data block carries a real CRC16. It replaces the simulation-only card model in hardware-in-loop tests of the SD controller, and is parametrised in block length, response delays, init busy count and capacity.

## Interface
- `BLOCK_LEN`, 512: data bytes per block; power of 2, 16..1024.
- `NCR`, 1: response delay after the command's last bit, in 0xFF bytes; 1..8.
- `NAC`, 2: delay between R1 and the 0xFE token, in 0xFF bytes; 1..255.
- `ACMD41_BUSY`, 1: number of ACMD41s answered 0x01 before the first 0x00; 0..15.
- `INIT_CLKS`, 74: SCLK rising edges with CS high required before CMD0 is accepted.
- `NUM_BLOCKS`, 65536: capacity; a CMD17 address at or above this value is out of range.
- `clk`  in  1: system clock; must be at least 8x the SCLK frequency.
- `rst_n`  in  1: synchronous, active-low reset.
- `sclk`, `cs_n`, `mosi`  in  1 each: host SPI inputs, asynchronous to `clk`.
- `miso`  out  1: registered SPI output.
- `rd_stb`  out  1: one-`clk` pulse requesting a data byte.
- `rd_blk`  out  32: block address of the current CMD17.
- `rd_idx`  out  $clog2(BLOCK_LEN): byte index being requested.
- `rd_data`  in  8: requested byte; sampled exactly 2 `clk` after `rd_stb`.
- `cmd_stb`  out  1: one-`clk` pulse when a complete 48-bit frame is received.
- `cmd_idx`  out  6: command index of the last frame.
- `card_ready`  out  1: high once ACMD41 has returned 0x00.

## Operation
- Input sync: `sclk`, `cs_n` and `mosi` each pass through 2 flops. SCLK rise/fall events are single-`clk` pulses derived from the synchronised copy.
- Power-up: count SCLK rises while `cs_n` is high, up to `INIT_CLKS`. Until the count is reached, all frames are ignored and `miso` stays 1.
- Rx: while CS is low and the main FSM is in RX, a 0 on MOSI sampled at an SCLK rise starts a frame. 48 bits are shifted MSB first. A frame is valid only if bit47=0 and bit46=1; otherwise the bits are discarded and the receiver hunts again.
- Main FSM states: RX → NCR_WAIT (`NCR` bytes of 0xFF) → RESP (R1, then 4 more bytes for R7) → NAC_WAIT → TOKEN (0xFE) → DATA (`BLOCK_LEN` bytes) → CRC (2 bytes) → RX. Commands that carry no data return to RX after RESP.
- Card flags: `idle` (set by CMD0, cleared by the successful ACMD41), `app` (set by CMD55, cleared after the next command of any kind), and the ACMD41 counter.
- R1 idle bit: bit0 of every R1 equals `idle` at the time the response is built.
- CMD0: CRC byte must be 0x95, else R1=0x09. On success: `idle`=1, ACMD41 counter cleared, `card_ready`=0, R1=0x01.
- CMD8: CRC byte must be 0x87, else R1=0x09. On success, R7 = R1, 0x00, 0x00, arg[11:8], arg[7:0].
- CMD55: R1 with idle bit, sets `app`.
- ACMD41 (`app` set): if the counter is below `ACMD41_BUSY`, increment it and answer 0x01. Otherwise answer 0x00, clear `idle`, set `card_ready`.
- CMD41 without a preceding CMD55, and any other index: R1 = 0x04 | idle.
- CMD17:
  - While `idle`: R1=0x05.
  - If arg >= `NUM_BLOCKS`: R1=0x40, no token.
  - Else: R1=0x00, `rd_blk`=arg, then the data phase. Block addressing only; CRC bytes of all commands except CMD0 and CMD8 are ignored.
- Data fetch: `rd_stb` pulses for byte k one `clk` after the first bit of the preceding byte (token or byte k-1) is driven. `rd_data` is captured 2 `clk` later into a prefetch register, which loads the output shifter at the byte boundary.
- CRC16: CCITT polynomial 0x1021, initial value 0x0000, computed over the data bytes MSB first and sent MSB byte first.

## Timing
- `miso` changes only on the `clk` after a detected SCLK fall: 3 `clk` after the pin edge. When not driving, `miso`=1.
- First response bit is driven at the first SCLK fall after `NCR`*8 idle bit-times following the command's last rise.
- `cs_n` rising at any time: FSM returns to RX, receiver cleared, `miso`=1 within 3 `clk`. Card flags and the power-up count are kept. No further `rd_stb` is issued.
- New frame bits arriving during RESP or DATA are ignored; the card is half-duplex.
- Reset values: `miso`=1, `rd_stb`=0, `rd_blk`=0, `rd_idx`=0, `cmd_stb`=0, `cmd_idx`=0, `card_ready`=0, FSM=RX, power-up count=0, `idle`=1, `app`=0.

## Test plan
- CMD0 sent after only 40 CS-high clocks → `cmd_stb`=0, `miso` stays 1. After 80 clocks, CMD0 40 00 00 00 00 95 → 0xFF ×1 then 0x01.
- CMD0 with CRC 0x00 → R1 0x09. CMD8 arg 0x1AA, CRC 0x87 → 01 00 00 01 AA.
- `ACMD41_BUSY`=2: three CMD55+ACMD41 pairs → ACMD41 answers 0x01, 0x01, 0x00; `card_ready` rises after the third.
- CMD17 arg 5, `rd_data`=`rd_idx`[7:0], `BLOCK_LEN`=16 → 0x00, `NAC` 0xFF bytes, FE, 00..0F, CRC matching the reference-model CRC16.
- CMD17 arg=`NUM_BLOCKS` → 0x40 and no FE. CMD17 before init → 0x05.
- `cs_n` raised at data byte 7 → `miso`=1 within 3 `clk`, no further `rd_stb`. The next CMD17 succeeds.
